uart_tx_arbiter: RTL

//  Shares the single UART transmitter among N_REQ byte producers with a round-robin policy.

---
 rtl/uart_ctrl_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared controller definitions for the UART/SPI/I2C front-end blocks:
// the common three-state transfer encoding, default byte width and a round-robin helper.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } ctrl_state_t;

    localparam int DATA_W_DEFAULT = 8;

    // Index following idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping
// past N_REQ-1 to 0. Produces a one-hot grant plus the winning index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [PTR_W-1:0]   offset;
    logic [PTR_W:0]     idx_sum;

    // Doubling the vector lets a plain part-select perform the wrap-around rotation.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N_REQ];

    always_comb begin
        offset      = '0;
        grant_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset      = PTR_W'(k);
                grant_valid = 1'b1;
            end
        end
    end

    assign idx_sum   = {1'b0, ptr} + {1'b0, offset};
    assign grant_idx = (idx_sum >= (PTR_W + 1)'(N_REQ))
                     ? PTR_W'(idx_sum - (PTR_W + 1)'(N_REQ))
                     : idx_sum[PTR_W-1:0];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant[gi] = grant_valid && (grant_idx == PTR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ byte producers.
// Define UART_TX_TIMEOUT_EN to abort a transfer whose tx_done never arrives.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        req_done,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_done,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int PTR_W = $clog2(N_REQ);

    generate
        if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("uart_tx_arbiter: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    ctrl_state_t         state_reg, state_next;
    logic [PTR_W-1:0]    ptr_reg;
    logic [PTR_W-1:0]    owner_reg;
    logic [DATA_W-1:0]   tx_data_reg;
    logic [N_REQ-1:0]    req_done_reg;

    logic [N_REQ-1:0]    arb_grant;
    logic [PTR_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [DATA_W-1:0]   req_bytes [N_REQ];
    logic [DATA_W-1:0]   win_byte;
    logic [N_REQ-1:0]    owner_onehot;
    logic                wait_done;
    logic                wait_exit;
    logic                timeout_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req         (req),
        .ptr         (ptr_reg),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // AND-OR byte mux keyed by the one-hot grant, avoiding a wide variable index.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign req_bytes[gi]    = arb_grant[gi] ? req_data[gi*DATA_W +: DATA_W] : '0;
            assign owner_onehot[gi] = (owner_reg == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        win_byte = '0;
        for (int k = 0; k < N_REQ; k++) begin
            win_byte = win_byte | req_bytes[k];
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_START) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    // A tx_done arriving on the limit cycle takes precedence over the abort.
    assign timeout_hit = (state_reg == ST_WAIT) && !tx_done
                      && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign wait_done = (state_reg == ST_WAIT) && tx_done;
    assign wait_exit = wait_done || timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (arb_valid) state_next = ST_START;
            ST_START: state_next = ST_WAIT;
            ST_WAIT:  if (wait_exit) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_start = 1'b0;
        gnt      = '0;
        busy     = 1'b1;
        case (state_reg)
            ST_IDLE:  busy = 1'b0;
            ST_START: begin
                tx_start = 1'b1;
                gnt      = owner_onehot;
            end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= '0;
            owner_reg    <= '0;
            tx_data_reg  <= '0;
            req_done_reg <= '0;
        end else begin
            req_done_reg <= wait_done ? owner_onehot : '0;
            if (state_reg == ST_IDLE && arb_valid) begin
                owner_reg   <= arb_idx;
                tx_data_reg <= win_byte;
            end
            // The owner just served drops to lowest priority, aborted or not.
            if (wait_exit) begin
                ptr_reg <= PTR_W'(rr_next(int'(owner_reg), N_REQ));
            end
        end
    end

    assign tx_data     = tx_data_reg;
    assign req_done    = req_done_reg;
    assign timeout_err = timeout_hit;

endmodule
